wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the ALU result path and the memory-load path
//  at the write-back stage. Memory loads win by default; ALU results queue in a small FIFO, with an
//  anti-starvation counter forcing an ALU grant. Drives registered rf write controls and a stall to decode.
// PARAMETERS
//  DATA_W       32  width of write data
//  ADDR_W       5   register index width
//  BUF_DEPTH    2   ALU result FIFO depth (power of 2, >=2)
//  STARVE_LIMIT 3   consecutive mem grants with non-empty FIFO before a forced ALU grant (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  alu_valid  in   1       ALU result offered
//  alu_ready  out  1       ALU result accepted this cycle when high with alu_valid
//  alu_rd     in   ADDR_W  ALU destination register
//  alu_data   in   DATA_W  ALU result
//  mem_valid  in   1       load data offered
//  mem_ready  out  1       load data accepted this cycle when high with mem_valid
//  mem_rd     in   ADDR_W  load destination register
//  mem_data   in   DATA_W  load data
//  rf_we      out  1       register-file write enable (registered)
//  rf_waddr   out  ADDR_W  register-file write address (registered)
//  rf_wdata   out  DATA_W  register-file write data (registered)
//  stall      out  1       FIFO full; upstream must hold the ALU result
//  grant      out  2       last grant: 0 IDLE, 1 MEM, 2 ALU, 3 FORCE
// BEHAVIOUR
//  - Reset (async, rst=1): FIFO count/pointers 0, starve_cnt 0, grant=IDLE, rf_we/rf_waddr/rf_wdata 0.
//  - alu_ready = !stall = (count < BUF_DEPTH), from registered count; no pass-through when full,
//    even if a pop occurs the same cycle. Accepted ALU beat is pushed; eligible for grant next cycle.
//  - Per-cycle grant decision (combinational, registered into grant):
//    FORCE: starve_cnt==STARVE_LIMIT && count>0 -> pop FIFO head; mem_ready=0.
//    MEM:   else mem_valid -> mem_ready=1, load written.
//    ALU:   else count>0 -> pop FIFO head.
//    IDLE:  else nothing written.  mem_ready=1 in every non-FORCE cycle.
//  - Latency: mem beat accepted cycle t -> rf_we at t+1; ALU beat accepted t -> earliest rf_we at t+2.
//  - rf_we=1 next cycle for any granted beat with rd!=0; rd==0 beats are consumed, rf_we=0, addr/data
//    still updated. When nothing granted, rf_we=0 and rf_waddr/rf_wdata hold.
//  - starve_cnt: +1 on MEM grant while count>0 (saturates at STARVE_LIMIT); cleared on ALU/FORCE
//    grant or when count==0.
//  - ALU results leave in strict push order; simultaneous push+pop keeps count; pointers wrap mod BUF_DEPTH.
//  - Reset mid-operation discards FIFO contents; no write issued for them.
// CONFIGURATION
//  WB_HAZARD_EN defined: adds inputs hz_rs1/hz_rs2 (ADDR_W) and outputs hz_hit1/hz_hit2 (1):
//    hz_hitN=1 combinationally when hz_rsN!=0 matches rd of any valid FIFO entry or of a mem beat
//    being accepted this cycle; decode stalls on it.
//  Undefined: those ports and the compare logic are absent; behaviour otherwise identical.
// TESTING
//  1 rst=1 then release; idle -> rf_we=0, stall=0, grant=0, alu_ready=1, mem_ready=1.
//  2 mem_valid,mem_rd=5,mem_data=0xDEADBEEF at t -> rf_we=1,rf_waddr=5,rf_wdata=0xDEADBEEF at t+1.
//  3 ALU rd=3 d=0x11 and rd=4 d=0x22 pushed, mem_valid held high -> 3 MEM grants, then FORCE
//    writes r3=0x11 with mem_ready=0 that cycle; r4 written on next FORCE after 3 more MEM grants.
//  4 Fill FIFO (2 beats) under mem pressure -> stall=1, alu_ready=0; third ALU beat held, accepted
//    cycle after first pop; order r-first, r-second, r-third on rf port.
//  5 mem_rd=0 data=0x55 -> accepted, rf_we=0 next cycle; rst pulse with 2 FIFO entries -> no writes.
//  6 WB_HAZARD_EN: FIFO holds rd=7, hz_rs1=7, hz_rs2=0 -> hz_hit1=1, hz_hit2=0; after pop hz_hit1=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: memory loads win, ALU results wait in a small FIFO, and a starvation counter forces ALU grants.
// Optional hazard-compare ports are compiled in with `define WB_HAZARD_EN.
module wb_port_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic [1:0]        grant
`ifdef WB_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0] hz_rs1,
  input  logic [ADDR_W-1:0] hz_rs2,
  output logic              hz_hit1,
  output logic              hz_hit2
`endif
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_MEM   = 2'd1,
    GNT_ALU   = 2'd2,
    GNT_FORCE = 2'd3
  } grant_e;

  logic [ADDR_W-1:0] fifo_rd_q   [BUF_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [BUF_DEPTH];

  logic [CNT_W-1:0]  count_q,  count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  grant_e            grant_q,  grant_d;
  logic              rf_we_q,  rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;

  // Ready comes only from the registered count, so a full FIFO never accepts even when popping.
  assign alu_ready = (count_q < DEPTH_C);
  assign stall     = ~alu_ready;
  assign push      = alu_valid & alu_ready;

  always_comb begin
    grant_d    = GNT_IDLE;
    mem_ready  = 1'b1;
    pop        = 1'b0;
    wr_rd      = '0;
    wr_data    = '0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    starve_d   = '0;

    if ((starve_q == LIMIT_C) && (count_q != '0)) begin
      grant_d = GNT_FORCE;
    end else if (mem_valid) begin
      grant_d = GNT_MEM;
    end else if (count_q != '0) begin
      grant_d = GNT_ALU;
    end

    mem_ready = (grant_d != GNT_FORCE);
    pop       = (grant_d == GNT_ALU) || (grant_d == GNT_FORCE);

    case (grant_d)
      GNT_MEM: begin
        wr_rd   = mem_rd;
        wr_data = mem_data;
      end
      GNT_ALU, GNT_FORCE: begin
        wr_rd   = fifo_rd_q[rd_ptr_q];
        wr_data = fifo_data_q[rd_ptr_q];
      end
      default: ;
    endcase

    // Beats to r0 are consumed and still update addr/data, but never assert the enable.
    if (grant_d != GNT_IDLE) begin
      rf_we_d    = (wr_rd != '0);
      rf_waddr_d = wr_rd;
      rf_wdata_d = wr_data;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    if ((count_q != '0) && (grant_d == GNT_MEM)) begin
      starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      grant_q    <= GNT_IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      grant_q    <= grant_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= alu_rd;
        fifo_data_q[wr_ptr_q] <= alu_data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant    = grant_q;

`ifdef WB_HAZARD_EN
  // Only occupied slots (offset from the read pointer below count) are compared.
  always_comb begin
    logic h1;
    logic h2;
    h1 = mem_valid && mem_ready && (mem_rd == hz_rs1);
    h2 = mem_valid && mem_ready && (mem_rd == hz_rs2);
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (fifo_rd_q[rd_ptr_q + PTR_W'(i)] == hz_rs1) h1 = 1'b1;
        if (fifo_rd_q[rd_ptr_q + PTR_W'(i)] == hz_rs2) h2 = 1'b1;
      end
    end
    hz_hit1 = h1 && (hz_rs1 != '0);
    hz_hit2 = h2 && (hz_rs2 != '0);
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a scoreboard of expected rf writes plus per-scenario inline checks.
module tb_wb_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          stall;
  logic [1:0]    grant;
`ifdef WB_HAZARD_EN
  logic [AW-1:0] hz_rs1;
  logic [AW-1:0] hz_rs2;
  logic          hz_hit1;
  logic          hz_hit2;
`endif

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  wb_port_arbiter #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .BUF_DEPTH   (2),
    .STARVE_LIMIT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .stall    (stall),
    .grant    (grant)
`ifdef WB_HAZARD_EN
    ,
    .hz_rs1   (hz_rs1),
    .hz_rs2   (hz_rs2),
    .hz_hit1  (hz_hit1),
    .hz_hit2  (hz_hit2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every asserted write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.a || rf_wdata !== e.d) begin
          n_fail++;
          $display("FAIL rf_write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_HAZARD_EN
    hz_rs1 = '0; hz_rs2 = '0;
`endif
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL reset_rf_we: got %b, required 0", rf_we); end
    n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL reset_stall: got %b, required 0", stall); end
    n_checks++; if (grant !== 2'd0)     begin n_fail++; $display("FAIL reset_grant: got %0d, required 0", grant); end
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready: got %b, required 1", alu_ready); end
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready: got %b, required 1", mem_ready); end
  endtask

  task automatic test_mem_latency();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL mem_lat_ready: got %b, required 1", mem_ready); end
    exp_q.push_back('{a: 5'd5, d: 32'hDEAD_BEEF});
    step();
    mem_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1)           begin n_fail++; $display("FAIL mem_lat_we: got %b, required 1", rf_we); end
    n_checks++; if (rf_waddr !== 5'd5)        begin n_fail++; $display("FAIL mem_lat_addr: got %0d, required 5", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mem_lat_data: got %h, required deadbeef", rf_wdata); end
    n_checks++; if (grant !== 2'd1)           begin n_fail++; $display("FAIL mem_lat_grant: got %0d, required 1", grant); end
    step();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mem_lat_idle_we: got %b, required 0", rf_we); end
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL mem_lat_idle_grant: got %0d, required 0", grant); end
  endtask

  task automatic test_starve_force();
    int unsigned k;
    bit          force_c;
    wr_t         alu_mdl[$];
    k = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = (c < 2);
      alu_rd    = (c == 0) ? 5'd3 : 5'd4;
      alu_data  = (c == 0) ? 32'h11 : 32'h22;
      mem_valid = 1'b1;
      mem_rd    = AW'(16 + (k % 8));
      mem_data  = 32'hA000_0000 + k;
      force_c   = (c == 4) || (c == 8);
      #1;
      n_checks++;
      if (mem_ready !== !force_c) begin
        n_fail++; $display("FAIL starve_mem_ready c=%0d: got %b, required %b", c, mem_ready, !force_c);
      end
      if (alu_valid) begin
        n_checks++;
        if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_alu_ready c=%0d: got %b, required 1", c, alu_ready); end
        alu_mdl.push_back('{a: alu_rd, d: alu_data});
      end
      if (force_c) exp_q.push_back(alu_mdl.pop_front());
      else begin
        exp_q.push_back('{a: mem_rd, d: mem_data});
        k++;
      end
      step();
      n_checks++;
      if (grant !== (force_c ? 2'd3 : 2'd1)) begin
        n_fail++; $display("FAIL starve_grant c=%0d: got %0d, required %0d", c, grant, force_c ? 3 : 1);
      end
      if (c == 4) begin
        n_checks++;
        if (rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
          n_fail++; $display("FAIL starve_force_r3: got addr=%0d data=%h, required addr=3 data=11", rf_waddr, rf_wdata);
        end
      end
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL starve_idle_grant: got %0d, required 0", grant); end
  endtask

  task automatic test_back_to_back_full();
    bit         av [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit         mv [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit         ar [9] = '{1, 1, 0, 0, 0, 1, 0, 1, 1};
    logic [1:0] eg [9] = '{1, 1, 1, 1, 3, 1, 2, 2, 0};
    logic [AW-1:0] brd  [3] = '{5'd11, 5'd12, 5'd13};
    logic [DW-1:0] bdat [3] = '{32'hA1, 32'hB2, 32'hC3};
    int unsigned ai;
    int unsigned k;
    wr_t alu_mdl[$];
    ai = 0;
    k  = 0;
    for (int c = 0; c < 9; c++) begin
      alu_valid = av[c];
      alu_rd    = brd[(ai < 3) ? ai : 2];
      alu_data  = bdat[(ai < 3) ? ai : 2];
      mem_valid = mv[c];
      mem_rd    = AW'(24 + (k % 4));
      mem_data  = 32'hB000_0000 + k;
      #1;
      n_checks++;
      if (alu_ready !== ar[c] || stall !== !ar[c]) begin
        n_fail++; $display("FAIL full_alu_ready c=%0d: got ready=%b stall=%b, required ready=%b", c, alu_ready, stall, ar[c]);
      end
      n_checks++;
      if (mem_ready !== (eg[c] != 2'd3)) begin
        n_fail++; $display("FAIL full_mem_ready c=%0d: got %b, required %b", c, mem_ready, eg[c] != 2'd3);
      end
      if (av[c] && ar[c]) begin
        alu_mdl.push_back('{a: alu_rd, d: alu_data});
        ai++;
      end
      if (eg[c] == 2'd1) begin
        exp_q.push_back('{a: mem_rd, d: mem_data});
        k++;
      end else if (eg[c] != 2'd0) begin
        exp_q.push_back(alu_mdl.pop_front());
      end
      step();
      n_checks++;
      if (grant !== eg[c]) begin
        n_fail++; $display("FAIL full_grant c=%0d: got %0d, required %0d", c, grant, eg[c]);
      end
    end
    n_checks++; if (ai !== 3) begin n_fail++; $display("FAIL full_accept_count: got %0d, required 3", ai); end
  endtask

  task automatic test_r0_and_reset();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
    #1;
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL r0_mem_ready: got %b, required 1", mem_ready); end
    step();
    mem_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %b, required 0", rf_we); end
    n_checks++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'h55) begin
      n_fail++; $display("FAIL r0_addr_data: got addr=%0d data=%h, required addr=0 data=55", rf_waddr, rf_wdata);
    end
    n_checks++; if (grant !== 2'd1) begin n_fail++; $display("FAIL r0_grant: got %0d, required 1", grant); end

    for (int c = 0; c < 2; c++) begin
      alu_valid = 1'b1;
      alu_rd    = (c == 0) ? 5'd21 : 5'd23;
      alu_data  = (c == 0) ? 32'h5A : 32'h5B;
      mem_valid = 1'b1;
      mem_rd    = 5'd22;
      mem_data  = 32'hC0 + c;
      exp_q.push_back('{a: 5'd22, d: 32'hC0 + c});
      step();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b, required 1", stall); end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b, required 0", stall); end
    n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL rst_mid_grant: got %0d, required 0", grant); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (rf_we !== 1'b0 || grant !== 2'd0) begin
        n_fail++; $display("FAIL rst_discard c=%0d: got we=%b grant=%0d, required we=0 grant=0", c, rf_we, grant);
      end
    end
  endtask

`ifdef WB_HAZARD_EN
  task automatic test_hazard();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    exp_q.push_back('{a: 5'd9, d: 32'h99});
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    hz_rs1 = 5'd7;
    hz_rs2 = 5'd0;
    #1;
    n_checks++; if (hz_hit1 !== 1'b1) begin n_fail++; $display("FAIL hz_fifo_hit1: got %b, required 1", hz_hit1); end
    n_checks++; if (hz_hit2 !== 1'b0) begin n_fail++; $display("FAIL hz_fifo_hit2: got %b, required 0", hz_hit2); end
    exp_q.push_back('{a: 5'd7, d: 32'h77});
    step();
    n_checks++; if (grant !== 2'd2)   begin n_fail++; $display("FAIL hz_pop_grant: got %0d, required 2", grant); end
    n_checks++; if (hz_hit1 !== 1'b0) begin n_fail++; $display("FAIL hz_after_pop: got %b, required 0", hz_hit1); end
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h70;
    #1;
    n_checks++; if (hz_hit1 !== 1'b1) begin n_fail++; $display("FAIL hz_mem_hit1: got %b, required 1", hz_hit1); end
    exp_q.push_back('{a: 5'd7, d: 32'h70});
    step();
    mem_valid = 1'b0;
    hz_rs1 = '0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_mem_latency();
    test_starve_force();
    test_back_to_back_full();
    test_r0_and_reset();
`ifdef WB_HAZARD_EN
    test_hazard();
`endif
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
